// File: rtl/dmd_pkg.sv
// Shared types and constants for the DMD control-line oneshot bank.
// Edge-select codes and the per-channel state encoding.
package dmd_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } oneshot_state_t;

endpackage

// File: rtl/oneshot_bank_if.sv
// Channel-vector bundle between DMD pins/frame capture and the oneshot bank.
// master drives raw inputs and controls, slave returns conditioned outputs.
interface oneshot_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] pulse_in;
    logic [CHANNELS-1:0] enable;
    logic [CHANNELS-1:0] clr_missed;
    logic [CHANNELS-1:0] pulse_out;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] missed;

    modport master (
        output pulse_in, enable, clr_missed,
        input  pulse_out, busy, missed
    );

    modport slave (
        input  pulse_in, enable, clr_missed,
        output pulse_out, busy, missed
    );
endinterface

// File: rtl/oneshot_chan.sv
// One conditioning channel: synchroniser, edge detect, pulse/hold-off FSM
// and sticky missed-edge flag.
module oneshot_chan
    import dmd_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int PULSE_CLKS   = 4,
    parameter int HOLDOFF_CLKS = 0,
    parameter int EDGE_MODE    = 0,
    parameter int RETRIGGER    = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pulse_in,
    input  logic enable,
    input  logic clr_missed,
    output logic pulse_out,
    output logic busy,
    output logic missed
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CLKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'((HOLDOFF_CLKS > 0) ? HOLDOFF_CLKS - 1 : 0);
    localparam bit HAS_HOLD = (HOLDOFF_CLKS > 0);
    localparam bit RETRIG   = (RETRIGGER != 0);

    // [0],[1] synchroniser, [2] history
    logic [2:0]       sync_q;
    logic [1:0]       prime_q;
    logic [CNT_W-1:0] cnt_q;
    oneshot_state_t   state_q;
    logic             edge_raw;
    logic             strobe;
    logic             discard;

    always_comb begin
        edge_raw = 1'b0;
        case (EDGE_MODE)
            EDGE_RISE: edge_raw = sync_q[1] & ~sync_q[2];
            EDGE_FALL: edge_raw = ~sync_q[1] & sync_q[2];
            default:   edge_raw = sync_q[1] ^ sync_q[2];
        endcase
    end

    // History is only trustworthy once three samples have been taken.
    assign strobe  = edge_raw & (prime_q == 2'd3);
    assign discard = strobe & enable & (state_q != IDLE)
                   & ~((state_q == PULSE) & RETRIG);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prime_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], pulse_in};
            if (prime_q != 2'd3)
                prime_q <= prime_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
        end else if (!enable) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (strobe) begin
                        state_q   <= PULSE;
                        cnt_q     <= PULSE_LOAD;
                        pulse_out <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                PULSE: begin
                    if (strobe && RETRIG) begin
                        cnt_q <= PULSE_LOAD;
                    end else if (cnt_q == '0) begin
                        pulse_out <= 1'b0;
                        if (HAS_HOLD) begin
                            state_q <= HOLDOFF;
                            cnt_q   <= HOLD_LOAD;
                        end else begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            missed <= 1'b0;
        else if (discard)
            missed <= 1'b1;
        else if (clr_missed)
            missed <= 1'b0;
    end

endmodule

// File: rtl/oneshot_bank.sv
// Bank of independent DMD control-line oneshots.
// Checks parameters and fans the bundle out to one channel per line.
module oneshot_bank
    import dmd_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 8,
    parameter int PULSE_CLKS   = 4,
    parameter int HOLDOFF_CLKS = 0,
    parameter int EDGE_MODE    = 0,
    parameter int RETRIGGER    = 0
) (
    input  logic           clk,
    input  logic           reset_n,
    oneshot_bank_if.slave  bus
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (CHANNELS < 1) begin : g_bad_chan
        $error("oneshot_bank: CHANNELS must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
        $error("oneshot_bank: CNT_W out of range");
    end
    if (PULSE_CLKS < 1 || PULSE_CLKS > CNT_MAX) begin : g_bad_pulse
        $error("oneshot_bank: PULSE_CLKS out of range");
    end
    if (HOLDOFF_CLKS < 0 || HOLDOFF_CLKS > CNT_MAX) begin : g_bad_hold
        $error("oneshot_bank: HOLDOFF_CLKS out of range");
    end
    if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_bad_edge
        $error("oneshot_bank: EDGE_MODE must be 0, 1 or 2");
    end
    if (RETRIGGER < 0 || RETRIGGER > 1) begin : g_bad_retrig
        $error("oneshot_bank: RETRIGGER must be 0 or 1");
    end

    logic [CHANNELS-1:0] pulse_vec;
    logic [CHANNELS-1:0] busy_vec;
    logic [CHANNELS-1:0] missed_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        oneshot_chan #(
            .CNT_W        (CNT_W),
            .PULSE_CLKS   (PULSE_CLKS),
            .HOLDOFF_CLKS (HOLDOFF_CLKS),
            .EDGE_MODE    (EDGE_MODE),
            .RETRIGGER    (RETRIGGER)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .pulse_in   (bus.pulse_in[i]),
            .enable     (bus.enable[i]),
            .clr_missed (bus.clr_missed[i]),
            .pulse_out  (pulse_vec[i]),
            .busy       (busy_vec[i]),
            .missed     (missed_vec[i])
        );
    end

    assign bus.pulse_out = pulse_vec;
    assign bus.busy      = busy_vec;
    assign bus.missed    = missed_vec;

endmodule

// File: tb/tb_oneshot_bank.sv
// Directed bench for oneshot_bank: four differently-parameterised banks
// driven with hand-built input vectors and hand-derived expectations.
module tb_oneshot_bank;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    oneshot_bank_if #(.CHANNELS(4)) ifa ();
    oneshot_bank_if #(.CHANNELS(4)) ifh ();
    oneshot_bank_if #(.CHANNELS(4)) ifr ();
    oneshot_bank_if #(.CHANNELS(4)) ifb ();

    oneshot_bank u_a (.clk(clk), .reset_n(reset_n), .bus(ifa));

    oneshot_bank #(.HOLDOFF_CLKS(3)) u_h (
        .clk(clk), .reset_n(reset_n), .bus(ifh));

    oneshot_bank #(.PULSE_CLKS(6), .RETRIGGER(1)) u_r (
        .clk(clk), .reset_n(reset_n), .bus(ifr));

    oneshot_bank #(.EDGE_MODE(2)) u_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic v);
        case (sel)
            0: ifa.pulse_in[0] = v;
            1: ifh.pulse_in[0] = v;
            2: ifr.pulse_in[0] = v;
            default: ifb.pulse_in[0] = v;
        endcase
    endtask

    function automatic logic get_out(input int sel);
        case (sel)
            0: return ifa.pulse_out[0];
            1: return ifh.pulse_out[0];
            2: return ifr.pulse_out[0];
            default: return ifb.pulse_out[0];
        endcase
    endfunction

    // Bit k of pat is the input level sampled at edge t0+k; the output
    // observed after edge t0+k is sample k.
    task automatic run_vec(input int sel, input logic [63:0] pat,
                           input int n, output int r1, output int r2,
                           output int highs, output int rises,
                           output int others);
        logic prev;
        logic cur;
        prev = 1'b0;
        r1 = -1; r2 = -1; highs = 0; rises = 0; others = 0;
        for (int k = 0; k < n; k++) begin
            set_in(sel, pat[k]);
            step();
            cur = get_out(sel);
            if (cur) highs++;
            if (cur && !prev) begin
                rises++;
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
            if (ifa.pulse_out[3:1] != 3'b000) others++;
            prev = cur;
        end
    endtask

    int  r1, r2, highs, rises, others;
    int  seen;
    logic m6, m7, p3, p4, b4;

    initial begin
        ifa.pulse_in = 4'b0010;
        ifh.pulse_in = '0;
        ifr.pulse_in = '0;
        ifb.pulse_in = '0;
        ifa.enable = '1; ifh.enable = '1;
        ifr.enable = '1; ifb.enable = '1;
        ifa.clr_missed = '0; ifh.clr_missed = '0;
        ifr.clr_missed = '0; ifb.clr_missed = '0;

        repeat (3) step();
        check("rst_pulse_out", 32'(ifa.pulse_out), 0);
        check("rst_busy", 32'(ifa.busy), 0);
        check("rst_missed", 32'(ifa.missed), 0);

        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (ifa.pulse_out[1]) seen++;
        end
        check("prime_no_pulse", 32'(seen), 0);

        // basic pulse, defaults
        run_vec(0, 64'hFFFFF, 24, r1, r2, highs, rises, others);
        check("basic_start", 32'(r1), 2);
        check("basic_width", 32'(highs), 4);
        check("basic_others", 32'(others), 0);
        check("basic_missed", 32'(ifa.missed[0]), 0);

        // hold-off: edges at 0, 5 (rejected), 9 (accepted)
        run_vec(1, 64'h663, 25, r1, r2, highs, rises, others);
        check("hold_rise1", 32'(r1), 2);
        check("hold_rise2", 32'(r2), 11);
        check("hold_highs", 32'(highs), 8);
        check("hold_missed", 32'(ifh.missed[0]), 1);

        // retrigger 3 cycles into a 6-cycle pulse
        run_vec(2, 64'h1B, 20, r1, r2, highs, rises, others);
        check("retrig_start", 32'(r1), 2);
        check("retrig_highs", 32'(highs), 9);
        check("retrig_rises", 32'(rises), 1);
        check("retrig_missed", 32'(ifr.missed[0]), 0);

        // both edges, input high 10 cycles
        run_vec(3, 64'h3FF, 24, r1, r2, highs, rises, others);
        check("both_rise1", 32'(r1), 2);
        check("both_rise2", 32'(r2), 12);
        check("both_highs", 32'(highs), 8);

        // missed set/clear; edge at 4 lands on PULSE's final cycle
        ifh.clr_missed[0] = 1'b1;
        step();
        ifh.clr_missed[0] = 1'b0;
        check("clr_alone_a", 32'(ifh.missed[0]), 0);
        m6 = 1'b0; m7 = 1'b0;
        for (int k = 0; k < 14; k++) begin
            ifh.pulse_in[0] = (k < 2) || (k == 4) || (k == 5);
            ifh.clr_missed[0] = (k == 6) || (k == 7);
            step();
            if (k == 6) m6 = ifh.missed[0];
            if (k == 7) m7 = ifh.missed[0];
        end
        ifh.clr_missed[0] = 1'b0;
        check("set_wins", 32'(m6), 1);
        check("clr_alone_b", 32'(m7), 0);

        // enable dropped mid-pulse on channel 2
        p3 = 1'b0;
        ifa.pulse_in[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 3) p3 = ifa.pulse_out[2];
        end
        ifa.enable[2] = 1'b0;
        step();
        p4 = ifa.pulse_out[2];
        b4 = ifa.busy[2];
        check("en_pulse_before", 32'(p3), 1);
        check("en_drop_pulse", 32'(p4), 0);
        check("en_drop_busy", 32'(b4), 0);
        ifa.pulse_in[2] = 1'b0;
        repeat (3) step();
        ifa.pulse_in[2] = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ifa.pulse_out[2]) seen++;
        end
        check("dis_missed", 32'(ifa.missed[2]), 0);
        ifa.enable[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ifa.pulse_out[2]) seen++;
        end
        check("reenable_no_pulse", 32'(seen), 0);

        // async reset mid-pulse on channel 3
        p3 = 1'b0;
        ifa.pulse_in[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 3) p3 = ifa.pulse_out[3];
        end
        check("rst_mid_before", 32'(p3), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_pulse", 32'(ifa.pulse_out[3]), 0);
        check("rst_mid_busy", 32'(ifa.busy[3]), 0);
        step();
        reset_n = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oneshot_bank.md
# oneshot_bank

Multi-channel, parametrised successor to the single-channel DMD signal oneshot. Each channel synchronises an asynchronous DMD control input, such as row latch, column clock or display enable, and detects a selected edge. On that edge it emits a clean, fixed-width `clk`-domain pulse. The pulse is followed by an optional hold-off window that rejects ringing and glitches. The block sits between the DMD input pins and the frame capture logic, replacing discrete 74LS123 conditioning for all control lines at once.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent channels.
- `CNT_W`, default 8: width of the per-channel pulse/hold-off counter.
- `PULSE_CLKS`, default 4: pulse width in `clk` cycles. Legal range 1 to 2^CNT_W−1.
- `HOLDOFF_CLKS`, default 0: dead time after the pulse, in `clk` cycles. Legal range 0 to 2^CNT_W−1.
- `EDGE_MODE`, default 0: trigger edge. 0 = rising, 1 = falling, 2 = both.
- `RETRIGGER`, default 0: 1 means an edge during PULSE restarts the pulse width.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pulse_in` in CHANNELS: raw asynchronous inputs.
- `enable` in CHANNELS: per-channel enable, synchronous to `clk`.
- `clr_missed` in CHANNELS: per-channel clear for the `missed` flag.
- `pulse_out` out CHANNELS: conditioned pulses, registered.
- `busy` out CHANNELS: channel is not in IDLE.
- `missed` out CHANNELS: sticky flag, set when a detected edge is discarded.

## Operation
- Per channel, the input path is a 2-flop synchroniser plus one history flop. The edge strobe is computed from the last two synchronised samples according to `EDGE_MODE`.
- Priming:
  - All synchroniser and history flops reset to 0.
  - The edge strobe is suppressed until 3 `clk` cycles after `reset_n` deasserts.
  - As a result, an input held high through reset produces no trigger.
- Channel state machine: IDLE → PULSE → HOLDOFF → IDLE.
  - IDLE, on edge with `enable` high: go to PULSE, load the counter with PULSE_CLKS−1, and set `pulse_out`=1.
  - PULSE: decrement the counter each cycle.
    - At 0 with HOLDOFF_CLKS>0: go to HOLDOFF, load HOLDOFF_CLKS−1, and set `pulse_out`=0.
    - At 0 with HOLDOFF_CLKS=0: go to IDLE and set `pulse_out`=0.
  - HOLDOFF: decrement the counter; at 0, go to IDLE.
- Edges outside IDLE:
  - In PULSE with RETRIGGER=1: reload PULSE_CLKS−1 and stay in PULSE.
  - Otherwise: the edge is ignored and `missed` is set.
  - This includes an edge landing on the final cycle of PULSE or HOLDOFF. The transition cycle does not accept a new trigger.
- `enable` low:
  - The channel goes to IDLE on the next clock and `pulse_out` drops.
  - Edges seen while disabled are discarded and do not set `missed`.
  - The synchroniser keeps running, so re-enabling does not create a spurious edge.
- `missed`:
  - Set by a discarded edge.
  - Cleared by `clr_missed`.
  - If set and clear happen in the same cycle, set wins.
- `busy` = (state != IDLE), registered with the state.
- Reset values: `pulse_out`=0, `busy`=0, `missed`=0, all states IDLE, all counters 0.
- Assertion `reset_n` low mid-pulse clears the channel immediately and asynchronously.
- Illegal parameter values (PULSE_CLKS=0 or out of range) are rejected with an elaboration-time `$error`.

## Timing
- Input edge first sampled at clock edge t0: `pulse_out` rises after edge t0+2 and falls after edge t0+2+PULSE_CLKS. It is high for exactly PULSE_CLKS cycles.
- `busy` is high from t0+2 through t0+2+PULSE_CLKS+HOLDOFF_CLKS−1.
- The earliest accepted next edge is sampled at t0+PULSE_CLKS+HOLDOFF_CLKS+1.
- Retrigger: an edge sampled at t1 during PULSE makes `pulse_out` fall after edge t1+2+PULSE_CLKS.
- Channels are fully independent, with no cross-channel arbitration.
- Minimum input pulse width that is guaranteed to be detected is 2 `clk` periods.

## Structure
- Package `dmd_pkg` holds:
  - the edge mode constants `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`;
  - the state enum `oneshot_state_t` {IDLE, PULSE, HOLDOFF}.
- Sub-module `oneshot_chan`: one complete channel (synchroniser, edge detect, FSM, counter, `missed` flag). It is instantiated CHANNELS times in a generate loop.
- Top level `oneshot_bank`: parameter checks and port fan-out only.

## Test plan
- **Basic pulse.** Defaults, channel 0 rising edge, input held high 20 cycles → `pulse_out[0]` high exactly 4 cycles, starting 2 cycles after the first sampling edge. Other channels stay 0.
- **Hold-off.** HOLDOFF_CLKS=3, second edge 5 cycles after the first → ignored and `missed[0]`=1. An edge 9 cycles after the first → accepted.
- **Retrigger.** RETRIGGER=1, PULSE_CLKS=6, second edge 3 cycles into the pulse → total high time is 3+6=9 cycles and `missed` stays 0.
- **Both-edge mode.** EDGE_MODE=2, input high for 10 cycles → two 4-cycle pulses, 10 cycles apart.
- **Reset and enable.** `pulse_in` high through reset release → no pulse. `reset_n` low mid-pulse → `pulse_out`=0 immediately. `enable` dropped mid-pulse → low next cycle. Re-enabling with a static input → no pulse.
- **Missed set/clear.** Discarded edge coincident with `clr_missed` → `missed` stays 1. `clr_missed` alone on the next cycle → 0.
